popcount_sequencer: RTL
=======================

Name: popcount_sequencer

Overview:
- Multi-cycle controller that time-shares the team's 3-input ones-counter datapath (a, b, c -> y1:y0 = number of ones) to compute the population count of a WIDTH-bit word.
- Captures a word on start and feeds it to the external ones-counter one 3-bit slice per cycle, LSB slice first.
- Accumulates the 2-bit results and reports the total with a one-cycle done pulse.
- Sits between a requesting unit and one shared combinational ones-counter instance.

Parameters:
- WIDTH, 12, input word width; must be a multiple of 3 and >= 3, otherwise elaboration fails with $error.
- NSLICE (localparam), WIDTH/3, number of slices/RUN cycles.
- CW (localparam), $clog2(WIDTH+1), result width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk.
- clear  input  1  synchronous abort.
- data_in  input  WIDTH  word to count; sampled only when start is accepted.
- oc_a  output  1  slice bit 2 to ones-counter.
- oc_b  output  1  slice bit 1 to ones-counter.
- oc_c  output  1  slice bit 0 to ones-counter.
- oc_y1  input  1  ones-counter result MSB (combinational return).
- oc_y0  input  1  ones-counter result LSB.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- count  output  CW  registered popcount of last completed word.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; shift reg, slice index, accumulator, count = 0; busy=0; done=0; oc_a/b/c=0. Asserting rst_n low mid-operation discards the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: load sh<=data_in, acc<=0, idx<=0, go to RUN.
  - clear has no effect in IDLE.
- RUN:
  - oc_a=sh[2], oc_b=sh[1], oc_c=sh[0]; all three are driven from registers, with no combinational path from start or data_in.
  - Each edge: acc<=acc+{oc_y1,oc_y0} (zero-extended to CW), sh<=sh>>3, idx<=idx+1.
  - At the edge where idx==NSLICE-1: count<=acc+{oc_y1,oc_y0}, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - start=1 in the DONE cycle is accepted exactly as in IDLE (back-to-back operation).
  - clear in DONE is ignored; the done pulse still completes.
- Outside RUN, oc_a/b/c=0; busy=1 only in RUN.
- Latency: start accepted at E0 -> busy high for NSLICE cycles (E0..E0+NSLICE) -> done high in the cycle after edge E0+NSLICE, with count valid in that same cycle.
- count holds its value through RUN and IDLE; it changes only on entry to DONE or on reset/clear.
- start while busy is ignored and data_in is not sampled.
- clear=1 in RUN: next state IDLE, acc<=0, count<=0, no done pulse. When clear and start are both high in RUN, clear wins and start is ignored.
- Arithmetic cannot overflow (max WIDTH fits CW bits); slice results are trusted as 0..3.

Test Plan (WIDTH=12, bench drives oc_y1:y0 from a behavioural 3-input ones-counter):
1. rst_n=0 then release -> busy=0, done=0, count=0, oc_a/b/c=0; no activity without start.
2. data_in=12'hFFF, 1-cycle start -> oc_{a,b,c}=111 for 4 cycles, busy high 4 cycles, done pulse in 5th cycle, count=12.
3. data_in=12'b101_001_110_011 -> slices presented in order 011,110,001,101; count=7. Then data_in=12'h000 -> count=0.
4. start re-pulsed mid-RUN with data_in=12'hFFF after first start with 12'h001 -> ignored, count=1, exactly one done pulse.
5. start held high through the DONE cycle with new data 12'h0F0 -> new RUN begins immediately after DONE; count=1 then 4 on the next done.
6. Abort mid-RUN: clear=1 in 2nd RUN cycle -> IDLE, count=0, no done. Separately, rst_n low mid-RUN -> immediate async reset to step-1 values.

Source files
------------

// File: rtl/popcount_sequencer.sv
// Multi-cycle popcount controller. It feeds a WIDTH-bit word, one 3-bit slice per
// cycle with the LSB slice first, to a shared external ones-counter and adds up the results.
module popcount_sequencer #(
  parameter  int WIDTH = 12,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic             oc_a,
  output logic             oc_b,
  output logic             oc_c,
  input  logic             oc_y1,
  input  logic             oc_y0,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic [1:0]       state_dbg
);

  localparam int NSLICE = WIDTH / 3;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_bad_width
    $error("popcount_sequencer: WIDTH must be a multiple of 3 and >= 3");
  end

  // Handshake: start is sampled on every rising edge but is only accepted in IDLE
  // or DONE, and data_in is captured on that same edge. done is high for one cycle,
  // and count is valid in that cycle. clear aborts RUN and takes priority over start.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  sh;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     acc;
  logic [CW-1:0]     slice_sum;
  logic              last;

  assign slice_sum = CW'({oc_y1, oc_y0});
  assign last      = (idx == IW'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN: begin
        if (clear)     state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      idx   <= '0;
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sh  <= data_in;
            acc <= '0;
            idx <= '0;
          end
        end
        RUN: begin
          if (clear) begin
            acc   <= '0;
            count <= '0;
          end else begin
            acc <= acc + slice_sum;
            sh  <= sh >> 3;
            idx <= idx + IW'(1);
            if (last) count <= acc + slice_sum;
          end
        end
        default: ;
      endcase
    end
  end

  // The ones-counter inputs come only from registers, so there is no path from start or data_in.
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign oc_a      = busy & sh[2];
  assign oc_b      = busy & sh[1];
  assign oc_c      = busy & sh[0];
  assign state_dbg = state;

endmodule
